// File: rtl/wb_arbiter2_if.sv
// Wishbone bus bundle shared by both masters and the RAM port of wb_arbiter2.
// Signals: addr/wdata/sel/we/cyc/stb flow initiator->target; rdata/ack/err flow back.
// Modports: master = initiator view, slave = target view (the arbiter's m0/m1 side).
interface wb_arbiter2_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        err;

  // The RAM never raises an error, so the initiator view toward it omits err;
  // err exists only on the arbiter-to-master side, where it carries watchdog aborts.
  modport master (output addr, wdata, sel, we, cyc, stb,
                  input  rdata, ack);
  modport slave  (input  addr, wdata, sel, we, cyc, stb,
                  output rdata, ack, err);
endinterface

// File: rtl/wb_arbiter2.sv
// Two-master to one-slave Wishbone arbiter (instruction bus m0, data bus m1) with watchdog abort.
// Latency: grant takes 1 cycle from IDLE; slave path and ack routing are combinational once owned.
// Backpressure: owner is held until it drops cyc; a non-owner simply waits with no ack.
// Ports: clk, rst_n (async active-low); m0/m1 (slave modport, masters' buses);
//        s (master modport, RAM side); owner (2'b00 none, 2'b01 m0, 2'b10 m1, registered).
module wb_arbiter2 #(
  parameter int unsigned FIXED_PRIO = 0,    // 1: m1 wins every tie
  parameter int unsigned TIMEOUT    = 255,  // waiting slave cycles before abort
  parameter int unsigned TO_W       = 16    // watchdog width, must hold TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_arbiter2_if.slave      m0,
  wb_arbiter2_if.slave      m1,
  wb_arbiter2_if.master     s,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    ABORT = 2'd3
  } state_e;

  localparam logic [TO_W-1:0] TIMEOUT_C = TO_W'(TIMEOUT);

  state_e          state_q;
  logic [1:0]      owner_q;
  logic            last_q;     // 0: m0 was granted last, 1: m1
  logic            err_q;
  logic [TO_W-1:0] wd_q;

  logic            own0;
  logic            own1;
  logic            own_cyc;
  logic            own_stb;
  logic            abort_cyc;
  logic            m0_wins;
  logic [TO_W-1:0] wd_inc;

  assign own0      = (state_q == OWN0);
  assign own1      = (state_q == OWN1);
  assign own_cyc   = (own0 & m0.cyc) | (own1 & m1.cyc);
  assign own_stb   = (own0 & m0.stb) | (own1 & m1.stb);
  // In ABORT the slave port is forced idle, so watch the owner's cyc directly.
  assign abort_cyc = owner_q[0] ? m0.cyc : m1.cyc;
  assign wd_inc    = wd_q + TO_W'(1);
  // Round-robin favours whoever was not granted last; fixed priority hands ties to m1.
  assign m0_wins   = m0.cyc && (!m1.cyc || (FIXED_PRIO == 0 && last_q));

  // Slave side: only the owner's request reaches the RAM.
  always_comb begin
    s.addr  = '0;
    s.wdata = '0;
    s.sel   = '0;
    s.we    = 1'b0;
    if (own0) begin
      s.addr  = m0.addr;
      s.wdata = m0.wdata;
      s.sel   = m0.sel;
      s.we    = m0.we;
    end else if (own1) begin
      s.addr  = m1.addr;
      s.wdata = m1.wdata;
      s.sel   = m1.sel;
      s.we    = m1.we;
    end
  end

  assign s.cyc = own_cyc;
  assign s.stb = own_stb;

  // Acks only pass in an OWN state, so a late ack during ABORT is swallowed.
  assign m0.ack   = own0 & s.ack;
  assign m1.ack   = own1 & s.ack;
  assign m0.err   = err_q & (owner_q == 2'b01);
  assign m1.err   = err_q & (owner_q == 2'b10);
  assign m0.rdata = s.rdata;
  assign m1.rdata = s.rdata;
  assign owner    = owner_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 2'b00;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          wd_q <= '0;
          if (m0_wins) begin
            state_q <= OWN0;
            owner_q <= 2'b01;
            last_q  <= 1'b0;
          end else if (m1.cyc) begin
            state_q <= OWN1;
            owner_q <= 2'b10;
            last_q  <= 1'b1;
          end
        end
        OWN0, OWN1: begin
          if (!own_cyc) begin
            state_q <= IDLE;
            owner_q <= 2'b00;
            wd_q    <= '0;
          end else if (s.ack) begin
            // Ack beats a coinciding timeout.
            wd_q <= '0;
          end else if (own_stb) begin
            wd_q <= wd_inc;
            // Err is registered, so it shows in the first ABORT cycle with the slave already idle.
            if (wd_inc == TIMEOUT_C) begin
              state_q <= ABORT;
              err_q   <= 1'b1;
            end
          end
        end
        ABORT: begin
          // Watchdog stays parked at TIMEOUT until the owner lets go.
          if (!abort_cyc) begin
            state_q <= IDLE;
            owner_q <= 2'b00;
            wd_q    <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          owner_q <= 2'b00;
        end
      endcase
    end
  end

endmodule
